// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-requester round-robin arbiter for a single data memory port
module data_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            req_read,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_address,
  input  logic [3:0]            req_size,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            grant,
  output logic [1:0]            done,
  output logic [1:0]            err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  read_request_to_mem,
  output logic                  write_request_to_mem,
  output logic [ADDR_W-1:0]     address_to_mem,
  output logic [1:0]            size_select_to_mem,
  output logic [DATA_W-1:0]     write_data_to_mem,
  input  logic [DATA_W-1:0]     read_data_from_mem,
  input  logic                  read_ready_from_mem,
  input  logic                  write_ready_from_mem,
  input  logic                  write_finished_from_mem
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_READ    = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // Last cycle count value before a missing response is declared a timeout.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic       owner;        // index of the requester currently served
  logic       rr_last;      // index granted most recently
  logic       rw_conflict;  // owner asked for read and write at once
  logic [7:0] cycle_cnt;

  logic [1:0] req_any;
  logic       sel;
  logic [1:0] owner_onehot;

  // The memory's write-ready handshake carries no information the FSM needs.
  logic unused_write_ready;
  assign unused_write_ready = write_ready_from_mem;

  // Pick the next requester: alternate on contention, otherwise take whoever asks.
  always_comb begin
    req_any = req_read | req_write;
    sel     = 1'b0;
    if (req_any == 2'b11) begin
      sel = ~rr_last;
    end else begin
      sel = req_any[1];
    end
    owner_onehot = {owner, ~owner};
  end

  // Transaction FSM: capture, issue, wait for response or timeout, release.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state                <= S_IDLE;
      owner                <= 1'b0;
      rr_last              <= 1'b1;
      rw_conflict          <= 1'b0;
      cycle_cnt            <= '0;
      grant                <= '0;
      done                 <= '0;
      err                  <= '0;
      rdata                <= '0;
      read_request_to_mem  <= 1'b0;
      write_request_to_mem <= 1'b0;
      address_to_mem       <= '0;
      size_select_to_mem   <= '0;
      write_data_to_mem    <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        S_IDLE: begin
          if (|req_any) begin
            owner              <= sel;
            rr_last            <= sel;
            grant              <= sel ? 2'b10 : 2'b01;
            address_to_mem     <= sel ? req_address[2*ADDR_W-1:ADDR_W] : req_address[ADDR_W-1:0];
            size_select_to_mem <= sel ? req_size[3:2] : req_size[1:0];
            write_data_to_mem  <= sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            cycle_cnt          <= '0;
            if (req_read[sel]) begin
              read_request_to_mem <= 1'b1;
              rw_conflict         <= req_write[sel];
              state               <= S_READ;
            end else begin
              write_request_to_mem <= 1'b1;
              rw_conflict          <= 1'b0;
              state                <= S_WRITE;
            end
          end
        end
        S_READ: begin
          if (read_ready_from_mem) begin
            rdata               <= read_data_from_mem;
            read_request_to_mem <= 1'b0;
            grant               <= '0;
            done                <= owner_onehot;
            err                 <= rw_conflict ? owner_onehot : 2'b00;
            state               <= S_RELEASE;
          end else if (cycle_cnt == CNT_LAST) begin
            read_request_to_mem <= 1'b0;
            grant               <= '0;
            done                <= owner_onehot;
            err                 <= owner_onehot;
            state               <= S_RELEASE;
          end else begin
            cycle_cnt <= cycle_cnt + 8'd1;
          end
        end
        S_WRITE: begin
          if (write_finished_from_mem) begin
            write_request_to_mem <= 1'b0;
            grant                <= '0;
            done                 <= owner_onehot;
            state                <= S_RELEASE;
          end else if (cycle_cnt == CNT_LAST) begin
            write_request_to_mem <= 1'b0;
            grant                <= '0;
            done                 <= owner_onehot;
            err                  <= owner_onehot;
            state                <= S_RELEASE;
          end else begin
            cycle_cnt <= cycle_cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   req_read;
  logic [1:0]   req_write;
  logic [127:0] req_address;
  logic [3:0]   req_size;
  logic [127:0] req_wdata;
  logic [1:0]   grant;
  logic [1:0]   done;
  logic [1:0]   err;
  logic [63:0]  rdata;
  logic         read_request_to_mem;
  logic         write_request_to_mem;
  logic [63:0]  address_to_mem;
  logic [1:0]   size_select_to_mem;
  logic [63:0]  write_data_to_mem;
  logic [63:0]  read_data_from_mem;
  logic         read_ready_from_mem;
  logic         write_ready_from_mem;
  logic         write_finished_from_mem;

  data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .req_read                (req_read),
    .req_write               (req_write),
    .req_address             (req_address),
    .req_size                (req_size),
    .req_wdata               (req_wdata),
    .grant                   (grant),
    .done                    (done),
    .err                     (err),
    .rdata                   (rdata),
    .read_request_to_mem     (read_request_to_mem),
    .write_request_to_mem    (write_request_to_mem),
    .address_to_mem          (address_to_mem),
    .size_select_to_mem      (size_select_to_mem),
    .write_data_to_mem       (write_data_to_mem),
    .read_data_from_mem      (read_data_from_mem),
    .read_ready_from_mem     (read_ready_from_mem),
    .write_ready_from_mem    (write_ready_from_mem),
    .write_finished_from_mem (write_finished_from_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  done;
    logic [1:0]  err;
    bit          chk_rdata;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   mem_respond = 1'b1;
  int   mem_wait = 0;
  logic [63:0] mem [logic [63:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] d, input logic [1:0] e, input bit c, input logic [63:0] r);
    exp_t x;
    x.done = d; x.err = e; x.chk_rdata = c; x.rdata = r;
    sb.push_back(x);
  endtask

  // Memory model: answers two cycles after the request; unwritten words read as a5a5a5a5_<addr>.
  initial begin
    read_ready_from_mem     = 1'b0;
    write_ready_from_mem    = 1'b0;
    write_finished_from_mem = 1'b0;
    read_data_from_mem      = '0;
    forever begin
      @(posedge clk);
      #1;
      read_ready_from_mem     = 1'b0;
      write_ready_from_mem    = 1'b0;
      write_finished_from_mem = 1'b0;
      if (rstn && mem_respond && (read_request_to_mem || write_request_to_mem)) begin
        write_ready_from_mem = write_request_to_mem;
        if (mem_wait == 2) begin
          mem_wait = 0;
          if (read_request_to_mem) begin
            read_ready_from_mem = 1'b1;
            read_data_from_mem  = mem.exists(address_to_mem) ? mem[address_to_mem]
                                                             : {32'ha5a5a5a5, address_to_mem[31:0]};
          end else begin
            write_finished_from_mem = 1'b1;
            mem[address_to_mem]     = write_data_to_mem;
          end
        end else begin
          mem_wait++;
        end
      end else begin
        mem_wait = 0;
      end
    end
  end

  // Scoreboard monitor: every done pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && done !== 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {62'd0, done}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("done", {62'd0, done}, {62'd0, e.done});
          check("err", {62'd0, err}, {62'd0, e.err});
          if (e.chk_rdata) check("rdata", rdata, e.rdata);
        end
      end
    end
  end

  task automatic expect_grant_next(input logic [1:0] g);
    @(negedge clk);
    check("grant", {62'd0, grant}, {62'd0, g});
  endtask

  task automatic wait_grant(input logic [1:0] g);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (grant !== 2'b00) begin
        seen = 1'b1;
        check("grant_wait", {62'd0, grant}, {62'd0, g});
      end
    end
    if (!seen) check("grant_timeout", 64'd0, 64'd1);
  endtask

  // Waits for done, checks request/grant release, then drops the masked requests.
  task automatic wait_done(input logic [1:0] drop_mask, input bit expect_resp,
                           input bit chk_addr, input logic [63:0] exp_addr, output int hi_cycles);
    bit seen = 1'b0;
    bit resp_prev = 1'b0;
    hi_cycles = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        seen = 1'b1;
        check("req_drop_at_done", {62'd0, read_request_to_mem, write_request_to_mem}, 64'd0);
        check("grant_at_done", {62'd0, grant}, 64'd0);
        if (expect_resp) check("done_after_resp", {63'd0, resp_prev}, 64'd1);
        req_read  = req_read & ~drop_mask;
        req_write = req_write & ~drop_mask;
      end else begin
        if (read_request_to_mem || write_request_to_mem) begin
          hi_cycles++;
          if (chk_addr) check("addr_hold", address_to_mem, exp_addr);
        end
        resp_prev = read_ready_from_mem | write_finished_from_mem;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rstn        = 1'b0;
    req_read    = '0;
    req_write   = '0;
    req_address = '0;
    req_size    = '0;
    req_wdata   = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", {62'd0, grant}, 64'd0);
    check("rst_done_err", {60'd0, done, err}, 64'd0);
    check("rst_mem_req", {62'd0, read_request_to_mem, write_request_to_mem}, 64'd0);
    check("rst_addr", address_to_mem, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Contention: 0 first, then 1, then 0 again.
    req_address = {64'h200, 64'h100};
    req_read    = 2'b11;
    push(2'b01, 2'b00, 1'b1, 64'ha5a5a5a5_00000100);
    push(2'b10, 2'b00, 1'b1, 64'ha5a5a5a5_00000200);
    expect_grant_next(2'b01);
    wait_done(2'b01, 1'b1, 1'b0, 64'd0, hi);
    wait_grant(2'b10);
    wait_done(2'b10, 1'b1, 1'b0, 64'd0, hi);
    @(negedge clk);
    req_address = {64'h210, 64'h110};
    req_read    = 2'b11;
    push(2'b01, 2'b00, 1'b1, 64'ha5a5a5a5_00000110);
    expect_grant_next(2'b01);
    wait_done(2'b11, 1'b1, 1'b0, 64'd0, hi);
    @(negedge clk);

    // Write then read back through requester 0.
    req_address[63:0] = 64'h18;
    req_size          = 4'b0011;
    req_wdata[63:0]   = 64'hfedcba0987654321;
    req_write         = 2'b01;
    push(2'b01, 2'b00, 1'b0, 64'd0);
    expect_grant_next(2'b01);
    check("wr_req_next", {63'd0, write_request_to_mem}, 64'd1);
    check("wr_size", {62'd0, size_select_to_mem}, 64'd3);
    check("wr_data", write_data_to_mem, 64'hfedcba0987654321);
    wait_done(2'b01, 1'b1, 1'b1, 64'h18, hi);
    @(negedge clk);
    req_read = 2'b01;
    push(2'b01, 2'b00, 1'b1, 64'hfedcba0987654321);
    expect_grant_next(2'b01);
    check("rd_req_next", {63'd0, read_request_to_mem}, 64'd1);
    wait_done(2'b01, 1'b1, 1'b0, 64'd0, hi);
    @(negedge clk);

    // Timeout: memory silent, rdata keeps the previous read.
    mem_respond       = 1'b0;
    req_address[63:0] = 64'h40;
    req_read          = 2'b01;
    push(2'b01, 2'b01, 1'b1, 64'hfedcba0987654321);
    expect_grant_next(2'b01);
    wait_done(2'b01, 1'b0, 1'b0, 64'd0, hi);
    // grant cycle was observed by expect_grant_next, so add it back
    check("timeout_req_cycles", 64'(hi + 1), 64'd8);
    mem_respond = 1'b1;
    @(negedge clk);

    // Read and write together on requester 1: served as read, err at done.
    req_address[127:64] = 64'h3a;
    req_size            = 4'b1000;
    req_read            = 2'b10;
    req_write           = 2'b10;
    push(2'b10, 2'b10, 1'b1, 64'ha5a5a5a5_0000003a);
    expect_grant_next(2'b10);
    check("rw_is_read", {62'd0, read_request_to_mem, write_request_to_mem}, 64'd2);
    check("rw_size", {62'd0, size_select_to_mem}, 64'd2);
    check("rw_addr", address_to_mem, 64'h3a);
    wait_done(2'b10, 1'b1, 1'b0, 64'd0, hi);
    @(negedge clk);

    // Address change mid-read must not reach the memory.
    req_address[63:0] = 64'h20;
    req_read          = 2'b01;
    push(2'b01, 2'b00, 1'b1, 64'ha5a5a5a5_00000020);
    expect_grant_next(2'b01);
    req_address[63:0] = 64'h28;
    wait_done(2'b01, 1'b1, 1'b1, 64'h20, hi);
    @(negedge clk);

    // Reset during a write from requester 0: aborted, pointer back to favour 0.
    mem_respond       = 1'b0;
    req_address[63:0] = 64'h50;
    req_write         = 2'b01;
    expect_grant_next(2'b01);
    check("wr_before_rst", {63'd0, write_request_to_mem}, 64'd1);
    @(negedge clk);
    rstn      = 1'b0;
    req_read  = '0;
    req_write = '0;
    @(negedge clk);
    check("rst_mid_mem_req", {62'd0, read_request_to_mem, write_request_to_mem}, 64'd0);
    check("rst_mid_grant", {62'd0, grant}, 64'd0);
    check("rst_mid_done", {62'd0, done}, 64'd0);
    rstn        = 1'b1;
    mem_respond = 1'b1;
    @(negedge clk);
    req_address = {64'h60, 64'h30};
    req_read    = 2'b11;
    push(2'b01, 2'b00, 1'b1, 64'ha5a5a5a5_00000030);
    expect_grant_next(2'b01);
    wait_done(2'b11, 1'b1, 1'b0, 64'd0, hi);
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
